// File: rtl/multi_edge_det_if.sv
// rtl/multi_edge_det_if.sv - channel input/output bundle for the multi-channel edge detector
interface multi_edge_det_if #(
  parameter int N     = 4,
  parameter int CNT_W = 4
);
  logic [N-1:0]       sig;
  logic [2*N-1:0]     mode;
  logic [N-1:0]       clr;
  logic [N-1:0]       level;
  logic [N-1:0]       edge_pulse;
  logic [N-1:0]       flag;
  logic [N*CNT_W-1:0] evt_cnt;
  logic               irq;

  modport master (
    output sig, mode, clr,
    input  level, edge_pulse, flag, evt_cnt, irq
  );

  modport slave (
    input  sig, mode, clr,
    output level, edge_pulse, flag, evt_cnt, irq
  );
endinterface

// File: rtl/multi_edge_det.sv
// rtl/multi_edge_det.sv - per-channel synchronise, debounce, qualified edge pulse, sticky flag and counter
module multi_edge_det #(
  parameter int N        = 4,
  parameter int SYNC_STG = 2,
  parameter int DB_CYC   = 3,
  parameter int CNT_W    = 4
) (
  input logic             clk,
  input logic             rst,
  multi_edge_det_if.slave bus
);

  // A DB_CYC of 1 still needs a one-bit counter so the compare stays legal.
  localparam int DB_W = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
  localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DB_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [N-1:0]       level_v;
  logic [N-1:0]       pulse_v;
  logic [N-1:0]       flag_v;
  logic [N*CNT_W-1:0] cnt_v;

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic [SYNC_STG-1:0] sync_sh;
    logic                sync_i;
    logic                filt_q;
    logic [DB_W-1:0]     db_q;
    logic [1:0]          mode_i;
    logic                accept;
    logic                qual;
    logic                pulse_q;
    logic                flag_q;
    logic [CNT_W-1:0]    cnt_q;

    assign sync_i = sync_sh[SYNC_STG-1];
    assign mode_i = bus.mode[2*i +: 2];

    // The filter flips on this edge when the mismatch has persisted DB_CYC edges.
    assign accept = (sync_i != filt_q) && (db_q == DB_LAST);

    // New level is sync_i: 1 means a rise (mode bit 0), 0 means a fall (mode bit 1).
    assign qual = accept && (sync_i ? mode_i[0] : mode_i[1]);

    // Synchroniser chain; bit SYNC_STG-1 is the oldest, settled sample.
    always_ff @(posedge clk) begin
      if (rst) begin
        sync_sh <= '0;
      end else begin
        sync_sh <= {sync_sh[SYNC_STG-2:0], bus.sig[i]};
      end
    end

    // Debounce: count consecutive mismatches, restart on any match, accept at DB_CYC.
    always_ff @(posedge clk) begin
      if (rst) begin
        filt_q <= 1'b0;
        db_q   <= '0;
      end else if (sync_i == filt_q) begin
        db_q <= '0;
      end else if (db_q == DB_LAST) begin
        filt_q <= sync_i;
        db_q   <= '0;
      end else begin
        db_q <= db_q + 1'b1;
      end
    end

    // Pulse, sticky flag and saturating counter all see the qualified edge on the same clock.
    always_ff @(posedge clk) begin
      if (rst) begin
        pulse_q <= 1'b0;
        flag_q  <= 1'b0;
        cnt_q   <= '0;
      end else begin
        pulse_q <= qual;
        if (qual) begin
          flag_q <= 1'b1;
        end else if (bus.clr[i]) begin
          flag_q <= 1'b0;
        end
        if (bus.clr[i]) begin
          cnt_q <= qual ? CNT_W'(1) : '0;
        end else if (qual && (cnt_q != CNT_MAX)) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end

    assign level_v[i]               = filt_q;
    assign pulse_v[i]               = pulse_q;
    assign flag_v[i]                = flag_q;
    assign cnt_v[i*CNT_W +: CNT_W]  = cnt_q;
  end

  assign bus.level      = level_v;
  assign bus.edge_pulse = pulse_v;
  assign bus.flag       = flag_v;
  assign bus.evt_cnt    = cnt_v;
  assign bus.irq        = |flag_v;

endmodule

// File: tb/tb_multi_edge_det.sv
// tb/tb_multi_edge_det.sv - directed self-checking bench for multi_edge_det
module tb_multi_edge_det;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;
  int   pc [4];

  multi_edge_det_if #(.N(4), .CNT_W(4)) bus ();

  multi_edge_det #(
    .N(4), .SYNC_STG(2), .DB_CYC(3), .CNT_W(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Advance n rising edges, sampling at the following falling edge; tally pulses.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
      for (int c = 0; c < 4; c++) if (bus.edge_pulse[c]) pc[c]++;
    end
  endtask

  task automatic clear_pc();
    for (int c = 0; c < 4; c++) pc[c] = 0;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    clear_pc();
    rst = 1'b1;
    bus.sig = '0;
    bus.mode = '0;
    bus.clr = '0;
    @(negedge clk);
    step(2);
    rst = 1'b0;
    check("rst_level", bus.level, 0);
    check("rst_pulse", bus.edge_pulse, 0);
    check("rst_flag", bus.flag, 0);
    check("rst_cnt", bus.evt_cnt, 0);
    check("rst_irq", bus.irq, 0);

    // (a) ch0 both edges, latency check
    bus.mode[1:0] = 2'b11;
    bus.sig[0] = 1'b1;
    step(4);
    check("a_pulse_early", bus.edge_pulse[0], 0);
    check("a_level_early", bus.level[0], 0);
    step(1);
    check("a_pulse", bus.edge_pulse, 4'b0001);
    check("a_level", bus.level[0], 1);
    check("a_flag", bus.flag[0], 1);
    check("a_cnt", bus.evt_cnt[3:0], 1);
    check("a_irq", bus.irq, 1);
    step(1);
    check("a_pulse_one_cycle", bus.edge_pulse[0], 0);
    check("a_flag_sticky", bus.flag[0], 1);

    // (b) ch1 rise mode, 2-cycle glitch
    clear_pc();
    bus.mode[3:2] = 2'b01;
    bus.sig[1] = 1'b1;
    step(2);
    bus.sig[1] = 1'b0;
    step(8);
    check("b_no_pulse", pc[1], 0);
    check("b_level", bus.level[1], 0);
    check("b_cnt", bus.evt_cnt[7:4], 0);
    check("b_flag", bus.flag[1], 0);

    // (c) ch2 fall mode, 1->0->1
    clear_pc();
    bus.mode[5:4] = 2'b10;
    bus.sig[2] = 1'b1;
    step(10);
    check("c_rise_ignored", pc[2], 0);
    bus.sig[2] = 1'b0;
    step(10);
    check("c_fall_pulse", pc[2], 1);
    check("c_level_low", bus.level[2], 0);
    bus.sig[2] = 1'b1;
    step(10);
    check("c_total_pulses", pc[2], 1);
    check("c_cnt", bus.evt_cnt[11:8], 1);
    check("c_level_high", bus.level[2], 1);

    // (d) ch3 both, saturation then clr coincident with pulse
    clear_pc();
    bus.mode[7:6] = 2'b11;
    for (int e = 0; e < 20; e++) begin
      bus.sig[3] = ~bus.sig[3];
      step(10);
    end
    check("d_pulses", pc[3], 20);
    check("d_cnt_sat", bus.evt_cnt[15:12], 15);
    check("d_flag", bus.flag[3], 1);
    bus.sig[3] = ~bus.sig[3];
    step(4);
    bus.clr[3] = 1'b1;
    step(1);
    bus.clr[3] = 1'b0;
    check("d_clr_pulse", bus.edge_pulse[3], 1);
    check("d_clr_cnt", bus.evt_cnt[15:12], 1);
    check("d_clr_flag", bus.flag[3], 1);
    step(2);
    bus.clr[3] = 1'b1;
    step(1);
    bus.clr[3] = 1'b0;
    check("d_clr_only_cnt", bus.evt_cnt[15:12], 0);
    check("d_clr_only_flag", bus.flag[3], 0);
    check("d_other_cnts", bus.evt_cnt[11:0], 12'h101);

    // (e) ch0 mode off still tracks level, then rise mode pulses
    clear_pc();
    bus.mode[1:0] = 2'b00;
    bus.sig[0] = 1'b0;
    step(10);
    check("e_off_no_pulse", pc[0], 0);
    check("e_off_level", bus.level[0], 0);
    check("e_off_cnt", bus.evt_cnt[3:0], 1);
    bus.mode[1:0] = 2'b01;
    bus.sig[0] = 1'b1;
    step(10);
    check("e_rise_pulse", pc[0], 1);
    check("e_rise_cnt", bus.evt_cnt[3:0], 2);

    // (f) reset mid-debounce with all inputs high
    bus.sig = 4'h0;
    step(10);
    bus.mode = 8'hFF;
    bus.sig = 4'hF;
    step(3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("f_rst_level", bus.level, 0);
    check("f_rst_pulse", bus.edge_pulse, 0);
    check("f_rst_flag", bus.flag, 0);
    check("f_rst_cnt", bus.evt_cnt, 0);
    check("f_rst_irq", bus.irq, 0);
    step(4);
    check("f_pulse_early", bus.edge_pulse, 0);
    step(1);
    check("f_pulse_all", bus.edge_pulse, 4'hF);
    check("f_level_all", bus.level, 4'hF);
    check("f_flag_all", bus.flag, 4'hF);
    check("f_cnt_all", bus.evt_cnt, 16'h1111);
    check("f_irq", bus.irq, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
